main_fsm: RTL and testbench

//  Multicycle control FSM; it produces the per-cycle control strobes that condlogic consumes.

---
 rtl/main_fsm_pkg.sv | 65 ++++++
 rtl/main_fsm_outdec.sv | 71 +++++++
 rtl/main_fsm.sv | 99 +++++++++
 tb/tb_main_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared definitions for the multicycle main control FSM: state codes,
// datapath select encodings, instruction class codes and the control word.
package main_fsm_pkg;

  // 4-bit state codes, FETCH=0 .. UNKNOWN=10; codes 11..15 are illegal.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // ALUSrcA encodings
  localparam logic [1:0] SRCA_RN    = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  // ALUSrcB encodings
  localparam logic [1:0] SRCB_RM    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ResultSrc encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  // Instruction class (Op) codes
  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;
  localparam logic [1:0] OP_UNDEF   = 2'b11;

  // 12-bit control word. ALUSrcA only ever selects Rn or PC, so just its
  // low bit is carried here; the top module zero-extends it.
  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // States that finish an instruction and hand control back to FETCH.
  function automatic logic is_terminal(input state_t s);
    case (s)
      MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN: is_terminal = 1'b1;
      default:                              is_terminal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_fsm_outdec.sv
// Moore output decoder: maps the current state to the 12-bit control word.
// Anything not listed for a state stays 0; illegal codes give all zeros.
module main_fsm_outdec
  import main_fsm_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  // Per-state control strobes and datapath selects
  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      FETCH: begin
        ctrl.ir_write   = 1'b1;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC[0];
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.alu_op     = 1'b0;
        ctrl.next_pc    = 1'b1;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC[0];
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      MEMADR: begin
        ctrl.alu_src_a  = SRCA_RN[0];
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b0;
      end
      MEMRD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      MEMWR: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
      end
      EXECUTER: begin
        ctrl.alu_src_a  = SRCA_RN[0];
        ctrl.alu_src_b  = SRCB_RM;
        ctrl.alu_op     = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alu_src_a  = SRCA_RN[0];
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_RN[0];
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.alu_op     = 1'b0;
        ctrl.branch     = 1'b1;
      end
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Multicycle main control FSM. Holds the state register and next-state
// logic and produces the per-cycle strobes consumed by condlogic.
// Optional performance counters (CycCnt/RetCnt) are built only when the
// macro MAIN_FSM_PERF_EN is defined.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  output logic             IRWrite,
  output logic             AdrSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             ALUOp,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch
`ifdef MAIN_FSM_PERF_EN
  ,
  output logic [CNT_W-1:0] CycCnt,
  output logic [CNT_W-1:0] RetCnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("main_fsm: CNT_W must be at least 1");
  end

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;

  // Only I (Funct[5]) and L (Funct[0]) steer the sequence.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // State register; reset drops to FETCH immediately, abandoning any instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  // Next-state logic; Op/Funct only matter in DECODE and MEMADR
  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_nxt = MEMADR;
          OP_DP:   state_nxt = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_nxt = BRANCH;
          default: state_nxt = UNKNOWN;
        endcase
      end
      MEMADR:             state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:              state_nxt = MEMWB;
      EXECUTER, EXECUTEI: state_nxt = ALUWB;
      default:            state_nxt = FETCH;
    endcase
  end

  main_fsm_outdec u_outdec (
    .state (state),
    .ctrl  (ctrl)
  );

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = {1'b0, ctrl.alu_src_a};
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;

`ifdef MAIN_FSM_PERF_EN
  // Cycle and retired-instruction counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      CycCnt <= '0;
      RetCnt <= '0;
    end else begin
      CycCnt <= CycCnt + CNT_W'(1);
      if (is_terminal(state) && (state_nxt == FETCH))
        RetCnt <= RetCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: a table of named instructions with hand-written
// expected output sequences, reset/abort corner cases, then random
// instructions checked against an instruction-level reference model.
module tb_main_fsm;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, ALUOp, NextPC, RegW, MemW, Branch;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
`ifdef MAIN_FSM_PERF_EN
  logic [CNT_W-1:0] CycCnt, RetCnt;
  logic [CNT_W-1:0] cyc_m, ret_m;
`endif

  main_fsm #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch)
`ifdef MAIN_FSM_PERF_EN
    ,
    .CycCnt    (CycCnt),
    .RetCnt    (RetCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       irw;
    logic       adr;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] rs;
    logic       aluop;
    logic       npc;
    logic       regw;
    logic       memw;
    logic       br;
  } outs_t;

  localparam outs_t O_F   = {1'b1, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_D   = {1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MA  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MR  = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_MWB = {1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam outs_t O_MWR = {1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam outs_t O_ER  = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_EI  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam outs_t O_AWB = {1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam outs_t O_BR  = {1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam outs_t O_Z   = '0;

  typedef struct packed {
    logic [1:0]      op;
    logic [5:0]      funct;
    logic [2:0]      len;
    outs_t [0:4]     seq;
  } vec_t;

  vec_t  vt [6];
  outs_t outs;
  int    checks = 0;
  int    errors = 0;

  assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, NextPC, RegW, MemW, Branch};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // One clock of an instruction: check current outputs, drive inputs
  // (real values only where the FSM samples them), advance one cycle.
  task automatic cyc(input outs_t e, input logic drive_real, input logic [1:0] op_i,
                     input logic [5:0] fn_i, input string nm);
    chk(nm, 32'(outs), 32'(e));
`ifdef MAIN_FSM_PERF_EN
    chk({nm, "/CycCnt"}, 32'(CycCnt), 32'(cyc_m));
    chk({nm, "/RetCnt"}, 32'(RetCnt), 32'(ret_m));
`endif
    if (drive_real) begin
      Op    = op_i;
      Funct = fn_i;
    end else begin
      Op    = 2'($urandom);
      Funct = 6'($urandom);
    end
    @(negedge clk);
    #1;
`ifdef MAIN_FSM_PERF_EN
    cyc_m = cyc_m + 1'b1;
`endif
  endtask

  task automatic run_seq(input logic [1:0] op_i, input logic [5:0] fn_i,
                         input outs_t [0:4] seq, input int len, input string nm);
    for (int i = 0; i < len; i++)
      cyc(seq[i], (i == 1) || (i == 2), op_i, fn_i, $sformatf("%s[%0d]", nm, i));
`ifdef MAIN_FSM_PERF_EN
    ret_m = ret_m + 1'b1;
`endif
  endtask

  // Instruction-level reference: expected output per cycle from the class rules.
  function automatic void model(input logic [1:0] op_i, input logic [5:0] fn_i,
                                output outs_t [0:4] seq, output int len);
    case (op_i)
      2'b01: begin
        if (fn_i[0]) begin seq = {O_F, O_D, O_MA, O_MR, O_MWB}; len = 5; end
        else         begin seq = {O_F, O_D, O_MA, O_MWR, O_Z};  len = 4; end
      end
      2'b00:   begin seq = {O_F, O_D, (fn_i[5] ? O_EI : O_ER), O_AWB, O_Z}; len = 4; end
      2'b10:   begin seq = {O_F, O_D, O_BR, O_Z, O_Z}; len = 3; end
      default: begin seq = {O_F, O_D, O_Z, O_Z, O_Z};  len = 3; end
    endcase
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    outs_t [0:4] mseq;
    int          mlen;
    logic [1:0]  rop;
    logic [5:0]  rfn;

    vt[0] = '{op: 2'b01, funct: 6'b011001, len: 3'd5, seq: {O_F, O_D, O_MA, O_MR, O_MWB}};
    vt[1] = '{op: 2'b01, funct: 6'b011000, len: 3'd4, seq: {O_F, O_D, O_MA, O_MWR, O_Z}};
    vt[2] = '{op: 2'b10, funct: 6'b100000, len: 3'd3, seq: {O_F, O_D, O_BR, O_Z, O_Z}};
    vt[3] = '{op: 2'b00, funct: 6'b000100, len: 3'd4, seq: {O_F, O_D, O_ER, O_AWB, O_Z}};
    vt[4] = '{op: 2'b00, funct: 6'b101000, len: 3'd4, seq: {O_F, O_D, O_EI, O_AWB, O_Z}};
    vt[5] = '{op: 2'b11, funct: 6'b010101, len: 3'd3, seq: {O_F, O_D, O_Z, O_Z, O_Z}};

    reset = 1'b0;
    Op    = 2'b00;
    Funct = 6'b000000;
    #1 reset = 1'b1;
    #1 chk("reset_async", 32'(outs), 32'(O_F));
    @(negedge clk);
    #1 chk("reset_held", 32'(outs), 32'(O_F));
    reset = 1'b0;
`ifdef MAIN_FSM_PERF_EN
    cyc_m = '0;
    ret_m = '0;
    chk("reset_cyc0", 32'(CycCnt), 32'd0);
`endif

    // Directed table: LDR, STR, B first so the counter totals can be checked.
    for (int k = 0; k < 6; k++) begin
      run_seq(vt[k].op, vt[k].funct, vt[k].seq, int'(vt[k].len), $sformatf("vec%0d", k));
`ifdef MAIN_FSM_PERF_EN
      if (k == 2) begin
        chk("perf_cyc_ldr_str_b", 32'(CycCnt), 32'd12);
        chk("perf_ret_ldr_str_b", 32'(RetCnt), 32'd3);
      end
`endif
    end

    // Abort a store in MEMADR with an asynchronous reset: no MemW may follow.
    cyc(O_F, 1'b1, 2'b01, 6'b011000, "abort_f");
    cyc(O_D, 1'b1, 2'b01, 6'b011000, "abort_d");
    chk("abort_memadr", 32'(outs), 32'(O_MA));
    Op    = 2'b01;
    Funct = 6'b011000;
    #1 reset = 1'b1;
    #1 chk("abort_async", 32'(outs), 32'(O_F));
`ifdef MAIN_FSM_PERF_EN
    chk("abort_cyc0", 32'(CycCnt), 32'd0);
    chk("abort_ret0", 32'(RetCnt), 32'd0);
`endif
    @(negedge clk);
    #1 chk("abort_held", 32'(outs), 32'(O_F));
    reset = 1'b0;
`ifdef MAIN_FSM_PERF_EN
    cyc_m = '0;
    ret_m = '0;
`endif
    run_seq(vt[2].op, vt[2].funct, vt[2].seq, 3, "post_abort_b");

    // Restart the counters and run exactly 16 cycles so the 4-bit CycCnt wraps.
    reset = 1'b1;
    #1 reset = 1'b0;
`ifdef MAIN_FSM_PERF_EN
    cyc_m = '0;
    ret_m = '0;
`endif
    run_seq(vt[0].op, vt[0].funct, vt[0].seq, 5, "wrap_ldr");
    run_seq(vt[1].op, vt[1].funct, vt[1].seq, 4, "wrap_str");
    run_seq(vt[3].op, vt[3].funct, vt[3].seq, 4, "wrap_dpr");
    run_seq(vt[2].op, vt[2].funct, vt[2].seq, 3, "wrap_b");
`ifdef MAIN_FSM_PERF_EN
    chk("wrap_cyc", 32'(CycCnt), 32'd0);
    chk("wrap_ret", 32'(RetCnt), 32'd4);
`endif
    chk("wrap_fetch", 32'(outs), 32'(O_F));

    // Random instruction stream against the reference model.
    for (int n = 0; n < 150; n++) begin
      rop = 2'($urandom);
      rfn = 6'($urandom);
      model(rop, rfn, mseq, mlen);
      run_seq(rop, rfn, mseq, mlen, $sformatf("rnd%0d_op%0d_fn%02h", n, rop, rfn));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
